// File: rtl/risc_v_mem_router_pkg.sv
// ============================================================================
// Module : risc_v_mem_router_pkg
// Brief  : Shared types and default decode windows for the data-memory router.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package risc_v_mem_router_pkg;

  typedef enum logic [1:0] {
    MRT_IDLE   = 2'd0,
    MRT_ACCESS = 2'd1,
    MRT_RESP   = 2'd2
  } mem_rt_state_t;

  localparam logic [31:0] TEXT_LOWER = 32'h0040_0000;
  localparam logic [31:0] TEXT_SIZE  = 32'h0000_1000;
  localparam logic [31:0] DATA_LOWER = 32'h1001_0000;
  localparam logic [31:0] DATA_SIZE  = 32'h0000_0800;
  localparam logic [31:0] STACK_BASE = 32'h7FFF_E800;
  localparam logic [31:0] STACK_SIZE = 32'h0000_0800;
  localparam logic [31:0] MMIO_LOWER = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_SIZE  = 32'h0000_0100;

endpackage

`default_nettype wire

// File: rtl/risc_v_mem_region_dec.sv
// ============================================================================
// Module : risc_v_mem_region_dec
// Brief  : Combinational window decoder; lowest-index window wins on overlap.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module risc_v_mem_region_dec
  import risc_v_mem_router_pkg::*;
#(
  parameter int                          ADDR_W      = 32,
  parameter int                          N_REGIONS   = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {MMIO_LOWER, STACK_BASE, DATA_LOWER, TEXT_LOWER},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE = {MMIO_SIZE, STACK_SIZE, DATA_SIZE, TEXT_SIZE}
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic [N_REGIONS-1:0] hit,
  output logic                 hit_any,
  output logic [ADDR_W-1:0]    offset
);

  logic [N_REGIONS-1:0] in_win;

  // Bounds carry one extra bit so base+size never wraps at the top of memory.
  generate
    for (genvar i = 0; i < N_REGIONS; i++) begin : g_win
      localparam logic [ADDR_W:0] LO = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
      localparam logic [ADDR_W:0] HI = LO + {1'b0, REGION_SIZE[i*ADDR_W +: ADDR_W]};
      assign in_win[i] = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    end
  endgenerate

  always_comb begin
    hit    = '0;
    offset = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (in_win[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        offset = addr - REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign hit_any = |in_win;

endmodule

`default_nettype wire

// File: rtl/risc_v_mem_router.sv
// ============================================================================
// Module : risc_v_mem_router
// Brief  : Registered LSU-to-region router, one access outstanding at a time.
//          Optional region-ack watchdog: RISC_V_MEM_ROUTER_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module risc_v_mem_router
  import risc_v_mem_router_pkg::*;
#(
  parameter int                          ADDR_W         = 32,
  parameter int                          DATA_W         = 32,
  parameter int                          N_REGIONS      = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE    = {MMIO_LOWER, STACK_BASE, DATA_LOWER, TEXT_LOWER},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE    = {MMIO_SIZE, STACK_SIZE, DATA_SIZE, TEXT_SIZE},
  parameter int                          TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_be,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [N_REGIONS-1:0]          rgn_sel,
  output logic                          rgn_write,
  output logic [ADDR_W-1:0]             rgn_addr,
  output logic [DATA_W-1:0]             rgn_wdata,
  output logic [DATA_W/8-1:0]           rgn_be,
  input  logic [N_REGIONS-1:0]          rgn_ack,
  input  logic [N_REGIONS*DATA_W-1:0]   rgn_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LSB_W = (BE_W > 1) ? $clog2(BE_W) : 1;

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  mem_rt_state_t state, state_nx;

  logic [N_REGIONS-1:0] dec_hit;
  logic                 dec_any;
  logic [ADDR_W-1:0]    dec_off;
  logic                 misaligned;
  logic                 go_access;
  logic                 sel_ack;
  logic                 expired;
  logic [DATA_W-1:0]    sel_rdata;

  logic                 lat_write;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;
  logic [BE_W-1:0]      lat_be;
  logic [N_REGIONS-1:0] lat_sel;

  risc_v_mem_region_dec #(
    .ADDR_W      (ADDR_W),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_dec (
    .addr    (req_addr),
    .hit     (dec_hit),
    .hit_any (dec_any),
    .offset  (dec_off)
  );

  // An unaligned address with any lane enabled reaches past the word boundary.
  assign misaligned = (BE_W > 1) && (req_addr[LSB_W-1:0] != '0) && (req_be != '0);
  assign go_access  = dec_any && !misaligned;
  assign sel_ack    = |(rgn_ack & lat_sel);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (lat_sel[i]) sel_rdata = sel_rdata | rgn_rdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef RISC_V_MEM_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Expire on the last silent cycle so ACCESS lasts exactly TIMEOUT_CYCLES.
  assign expired = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != MRT_ACCESS) to_cnt <= '0;
    else if (!sel_ack)              to_cnt <= to_cnt + 1'b1;
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= MRT_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MRT_IDLE:   if (req_valid) state_nx = go_access ? MRT_ACCESS : MRT_RESP;
      MRT_ACCESS: if (sel_ack || expired) state_nx = MRT_RESP;
      MRT_RESP:   if (rsp_ready) state_nx = MRT_IDLE;
      default:    state_nx = MRT_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == MRT_IDLE);
    rsp_valid = (state == MRT_RESP);
    rgn_sel   = (state == MRT_ACCESS) ? lat_sel : '0;
  end

  assign rgn_write = lat_write;
  assign rgn_addr  = lat_addr;
  assign rgn_wdata = lat_wdata;
  assign rgn_be    = lat_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_sel   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        MRT_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= dec_off;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_sel   <= go_access ? dec_hit : '0;
            rsp_rdata <= '0;
            rsp_err   <= !go_access;
          end
        end
        MRT_ACCESS: begin
          if (sel_ack) begin
            rsp_rdata <= lat_write ? '0 : sel_rdata;
            rsp_err   <= 1'b0;
          end else if (expired) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/risc_v_mem_router.md
Name: risc_v_mem_router

Overview:
- Registered, parametrised data-memory router for the RISC-V core.
- Accepts one load/store request at a time from the LSU bus and decodes it against N_REGIONS programmable windows (text, data, stack, MMIO by default).
- Forwards the access with a region-relative offset to the selected region, waits for that region's acknowledge, and returns read data or an error on a valid/ready response channel.
- Sits between the LSU and the per-region memories/MMIO.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; DATA_W/8 byte enables.
- N_REGIONS, 4, number of decode windows.
- REGION_BASE, {32'hFFFF0000, 32'h7FFFE800, 32'h10010000, 32'h00400000}, packed N_REGIONS*ADDR_W array of window bases; index 0 is the LSBs.
- REGION_SIZE, {32'h100, 32'h800, 32'h800, 32'h1000}, packed window sizes in bytes.
- TIMEOUT_CYCLES, 64, region-ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  router can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_be  in  DATA_W/8  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  load data; 0 on store or error
- rsp_err  out  1  unmapped, misaligned or timed-out access
- rgn_sel  out  N_REGIONS  one-hot region strobe
- rgn_write  out  1  store qualifier
- rgn_addr  out  ADDR_W  req_addr - REGION_BASE[i]
- rgn_wdata  out  DATA_W  latched store data
- rgn_be  out  DATA_W/8  latched byte enables
- rgn_ack  in  N_REGIONS  per-region completion
- rgn_rdata  in  N_REGIONS*DATA_W  per-region read data

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, req_ready=1 one cycle after reset release, rsp_valid=0, rsp_err=0, rsp_rdata=0, rgn_sel=0, rgn_write=0, all latched fields 0.
- Reset mid-operation: any in-flight request and pending response are dropped, with no response issued.
- Hit rule: REGION_BASE[i] <= addr < REGION_BASE[i]+REGION_SIZE[i]. The upper bound is exclusive; the sum is computed at ADDR_W+1 bits so no wrap-around occurs.
- Overlapping windows: the lowest index wins.
- Misaligned: any req_be bit set outside the naturally aligned word (addr[1:0]!=0 with DATA_W=32) -> error.
- IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata/be and decode.
  - Hit and aligned -> ACCESS next cycle.
  - Otherwise -> RESP next cycle with rsp_err=1.
- ACCESS: req_ready=0; rgn_sel one-hot held stable; rgn_addr/wdata/be/write driven from the latches.
  - When rgn_ack of the selected region is 1: capture rgn_rdata slice (loads) or 0 (stores), set rsp_err=0, go to RESP.
  - Ack bits of unselected regions are ignored.
- RESP: rgn_sel=0, rsp_valid=1, data and err held stable until rsp_ready; then go to IDLE.
- Back-to-back: a new request is accepted only in IDLE, so at most one access is outstanding.
- Latency from the accept edge:
  - Hit with immediate ack: rsp_valid after 2 cycles.
  - Miss: rsp_valid after 1 cycle.
  - Each extra ack-wait cycle adds 1.
- rsp_valid never drops without rsp_ready.

Optional Feature:
- Macro: RISC_V_MEM_ROUTER_TIMEOUT_EN.
- Defined: a counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop rgn_sel, go to RESP with rsp_err=1, rsp_rdata=0.
  - An ack arriving in the same cycle as expiry wins.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- risc_v_mike_pkg gains:
  - typedef enum mem_rt_state_t {MRT_IDLE, MRT_ACCESS, MRT_RESP};
  - default region base/size constants (TEXT_LOWER, DATA_LOWER, STACK region base, MMIO_LOWER, plus the sizes).
- Sub-module risc_v_mem_region_dec: combinational, parametrised by N_REGIONS/bases/sizes. Inputs addr; outputs one-hot hit, hit_any, and the selected offset. It is instantiated once at the accept point.

Test Plan:
- Load 0x10010004, data region acks in the same cycle with rdata 0xDEADBEEF -> rgn_sel=4'b0010, rgn_addr=0x4, rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store 0x7FFFEFFC, be=4'hF, wdata=0x12345678, stack acks after 3 wait cycles -> rgn_sel=4'b0100, rgn_addr=0x7FC, rgn_wdata=0x12345678, rsp_valid after 5 cycles, rsp_rdata=0.
- Boundaries: load 0x10010800 (first byte past the data window) -> rsp_err=1 after 1 cycle, rgn_sel never asserted; load 0x100107FC -> hit data region.
- Misaligned load 0x00400002 with be=4'hF -> rsp_err=1, no region strobe; then rsp_ready held 0 for 4 cycles -> rsp_valid/err stay stable and req_ready=0 throughout.
- rst asserted in ACCESS for MMIO 0xFFFF0010 -> next cycle rgn_sel=0, rsp_valid=0, req_ready=1, and a later ack is ignored.
- With RISC_V_MEM_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=64, load 0x00400000 never acked -> rsp_err=1 after 64 ACCESS cycles. Without the macro, no response appears after 200 cycles.
